// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: packet FSM encoding, status-byte bit positions and default screen/timeout limits.
package ps2_mouse_pkg;

    localparam logic [1:0] S_B0 = 2'd0;
    localparam logic [1:0] S_B1 = 2'd1;
    localparam logic [1:0] S_B2 = 2'd2;

    localparam int BIT_LEFT  = 0;
    localparam int BIT_RIGHT = 1;
    localparam int BIT_MID   = 2;
    localparam int BIT_SYNC  = 3;
    localparam int BIT_XSIGN = 4;
    localparam int BIT_YSIGN = 5;
    localparam int BIT_XOVF  = 6;
    localparam int BIT_YOVF  = 7;

    localparam int H_MAX_DEF   = 639;
    localparam int V_MAX_DEF   = 479;
    localparam int TIMEOUT_DEF = 100000;

endpackage

// File: rtl/ps2_axis_clamp.sv
// ps2_axis_clamp: applies a 9-bit signed delta to one cursor axis, holds on overflow, clamps to [0, MAX].
module ps2_axis_clamp #(
    parameter int MAX = 639
) (
    input  logic [15:0] pos,
    input  logic [8:0]  delta,
    input  logic        sub,
    input  logic        hold,
    output logic [15:0] next
);

    localparam logic signed [17:0] LIM = 18'(MAX);

    logic signed [17:0] p, d, s;

    always_comb begin
        p = {2'b00, pos};
        d = {{9{delta[8]}}, delta};
        s = sub ? p - d : p + d;
        next = hold ? pos : s < 0 ? 16'd0 : s > LIM ? 16'(MAX) : s[15:0];
    end

endmodule

// File: rtl/ps2_packet_tracker.sv
// ps2_packet_tracker: assembles 3-byte PS/2 mouse packets and tracks a clamped cursor and button state.
module ps2_packet_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int H_MAX       = H_MAX_DEF,
    parameter int V_MAX       = V_MAX_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [15:0] Xpos,
    output logic [15:0] Ypos,
    output logic [2:0]  key_down,
    output logic        oTrig
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [7:0]    status, b1, b2;
    logic          commit;
    logic [15:0]   x_next, y_next;

    ps2_axis_clamp #(.MAX(H_MAX)) u_x (
        .pos(Xpos), .delta({status[BIT_XSIGN], b1}), .sub(1'b0),
        .hold(status[BIT_XOVF]), .next(x_next)
    );

    ps2_axis_clamp #(.MAX(V_MAX)) u_y (
        .pos(Ypos), .delta({status[BIT_YSIGN], b2}), .sub(1'b1),
        .hold(status[BIT_YOVF]), .next(y_next)
    );

    // The third byte is captured first and committed one edge later, so the clamp sees registered operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_B0;
            cnt      <= '0;
            status   <= '0;
            b1       <= '0;
            b2       <= '0;
            commit   <= 1'b0;
            Xpos     <= 16'(H_MAX / 2 + 1);
            Ypos     <= 16'(V_MAX / 2 + 1);
            key_down <= '0;
            oTrig    <= 1'b0;
        end else begin
            commit <= rx_valid && !rx_err && state == S_B2 && status[BIT_SYNC];
            oTrig  <= commit;
            if (commit) begin
                Xpos     <= x_next;
                Ypos     <= y_next;
                key_down <= {status[BIT_MID], status[BIT_RIGHT], status[BIT_LEFT]};
            end
            if (rx_err) begin
                state <= S_B0;
                cnt   <= '0;
            end else if (rx_valid) begin
                cnt   <= '0;
                state <= state == S_B0 ? (rx_data[BIT_SYNC] ? S_B1 : S_B0) : state == S_B1 ? S_B2 : S_B0;
                if (state == S_B0 && rx_data[BIT_SYNC]) status <= rx_data;
                if (state == S_B1) b1 <= rx_data;
                if (state == S_B2) b2 <= rx_data;
            end else if (state != S_B0) begin
                if (cnt == CW'(TIMEOUT_CYC)) begin
                    state <= S_B0;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_packet_tracker.sv
// tb_ps2_packet_tracker: directed packet sequences with a scoreboard of expected cursor/button states per commit.
module tb_ps2_packet_tracker;

    localparam int H_MAX = 639;
    localparam int V_MAX = 479;
    localparam int TO    = 50;

    typedef struct {
        int x;
        int y;
        int k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [15:0] Xpos, Ypos;
    logic [2:0]  key_down;
    logic        oTrig;

    int   checks = 0;
    int   errors = 0;
    int   trig_cnt = 0;
    int   mx, my, mk, n0;
    exp_t q[$];

    ps2_packet_tracker #(.H_MAX(H_MAX), .V_MAX(V_MAX), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .Xpos(Xpos), .Ypos(Ypos), .key_down(key_down), .oTrig(oTrig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every oTrig pops the oldest expected packet result.
    always @(negedge clk) begin
        if (oTrig) begin
            trig_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_trig", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_x", int'(Xpos), e.x);
                chk("sb_y", int'(Ypos), e.y);
                chk("sb_key", int'(key_down), e.k);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mx = 320;
        my = 240;
        mk = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = err;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy, nx, ny;
        exp_t e;
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        nx = mx + dx;
        ny = my - dy;
        nx = nx < 0 ? 0 : nx > H_MAX ? H_MAX : nx;
        ny = ny < 0 ? 0 : ny > V_MAX ? V_MAX : ny;
        if (!b0[6]) mx = nx;
        if (!b0[7]) my = ny;
        mk = int'(b0[2:0]);
        e.x = mx;
        e.y = my;
        e.k = mk;
        q.push_back(e);
        send(b0);
        send(b1);
        send(b2);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        do_reset();
        chk("rst_x", int'(Xpos), 320);
        chk("rst_y", int'(Ypos), 240);
        chk("rst_key", int'(key_down), 0);
        chk("rst_trig", int'(oTrig), 0);

        // Test 1: commit latency and basic movement
        n0 = trig_cnt;
        send_pkt(8'h09, 8'h0A, 8'h05);
        @(negedge clk);
        chk("t1_trig_level", int'(oTrig), 1);
        chk("t1_x", int'(Xpos), 330);
        chk("t1_y", int'(Ypos), 235);
        chk("t1_key", int'(key_down), 1);
        @(negedge clk);
        chk("t1_trig_pulse", int'(oTrig), 0);
        settle();
        chk("t1_trigs", trig_cnt - n0, 1);

        // Test 2: negative clamp, packets back to back
        do_reset();
        n0 = trig_cnt;
        send_pkt(8'h18, 8'h00, 8'h00);
        send_pkt(8'h18, 8'h00, 8'h00);
        settle();
        chk("t2_x", int'(Xpos), 0);
        chk("t2_trigs", trig_cnt - n0, 2);

        // Test 2b: upper clamp on both axes
        do_reset();
        send_pkt(8'h28, 8'hFF, 8'h00);
        send_pkt(8'h28, 8'hFF, 8'h00);
        settle();
        chk("t2b_x", int'(Xpos), 639);
        chk("t2b_y", int'(Ypos), 479);

        // Test 3: stray byte without sync bit is dropped
        do_reset();
        n0 = trig_cnt;
        send(8'h05);
        send_pkt(8'h08, 8'h01, 8'h01);
        settle();
        chk("t3_x", int'(Xpos), 321);
        chk("t3_y", int'(Ypos), 239);
        chk("t3_trigs", trig_cnt - n0, 1);

        // Test 4: partial packet timed out
        do_reset();
        n0 = trig_cnt;
        send(8'h08);
        send(8'h10);
        repeat (TO + 1) @(negedge clk);
        send_pkt(8'h08, 8'h02, 8'h00);
        settle();
        chk("t4_x", int'(Xpos), 322);
        chk("t4_y", int'(Ypos), 240);
        chk("t4_trigs", trig_cnt - n0, 1);

        // Test 5: X overflow holds X only
        do_reset();
        n0 = trig_cnt;
        send_pkt(8'h48, 8'h7F, 8'h03);
        settle();
        chk("t5_x", int'(Xpos), 320);
        chk("t5_y", int'(Ypos), 237);
        chk("t5_trigs", trig_cnt - n0, 1);

        // Test 6a: rx_err coincident with byte 2 drops the packet
        do_reset();
        n0 = trig_cnt;
        send(8'h08);
        send(8'h05);
        send(8'h05, 1'b1);
        settle();
        chk("t6a_trigs", trig_cnt - n0, 0);
        chk("t6a_x", int'(Xpos), 320);
        chk("t6a_y", int'(Ypos), 240);
        send_pkt(8'h09, 8'h01, 8'h01);
        settle();
        chk("t6a_resync_x", int'(Xpos), 321);
        chk("t6a_resync_key", int'(key_down), 1);

        // Test 6b: reset after byte 1 discards the partial packet
        send(8'h0A);
        send(8'h03);
        n0 = trig_cnt;
        do_reset();
        settle();
        chk("t6b_trigs", trig_cnt - n0, 0);
        chk("t6b_x", int'(Xpos), 320);
        chk("t6b_key", int'(key_down), 0);
        send_pkt(8'h08, 8'h04, 8'h00);
        settle();
        chk("t6b_x_after", int'(Xpos), 324);
        chk("t6b_key_after", int'(key_down), 0);

        chk("sb_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_packet_tracker.md
PS2_PACKET_TRACKER -- requirements
Module: ps2_packet_tracker

Interface
REQ-001 SHALL have parameter H_MAX, default 639: largest legal X position.
REQ-002 SHALL have parameter V_MAX, default 479: largest legal Y position.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000: maximum clk cycles allowed between bytes of one packet.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port rx_data, input, 8: received PS/2 byte from the byte receiver.
REQ-007 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port rx_err, input, 1: one-cycle strobe for a framing/parity error from the receiver.
REQ-009 SHALL have port Xpos, output, 16: cursor X, unsigned, 0..H_MAX.
REQ-010 SHALL have port Ypos, output, 16: cursor Y, unsigned, 0..V_MAX, screen-down positive.
REQ-011 SHALL have port key_down, output, 3: bit0 left, bit1 right, bit2 middle button held.
REQ-012 SHALL have port oTrig, output, 1: one-cycle pulse on each committed packet.

Function
REQ-013 SHALL run FSM with states B0, B1, B2, collecting bytes 0, 1 and 2 of a standard 3-byte packet.
REQ-014 In B0, a valid byte with bit3=1 SHALL be latched as status; transition to B1.
REQ-015 In B0, a valid byte with bit3=0 SHALL be discarded; the FSM stays in B0 (resync).
REQ-016 In B1, a valid byte SHALL be latched as dx; transition to B2.
REQ-017 In B2, a valid byte SHALL be taken as dy; transition to B0 and commit the packet.
REQ-018 dx SHALL be the 9-bit signed value {status[4], byte1}; dy SHALL be {status[5], byte2}.
REQ-019 Commit SHALL compute X_new = Xpos + dx and Y_new = Ypos - dy in at least 17-bit signed arithmetic.
REQ-020 Commit SHALL clamp each result to [0, H_MAX] or [0, V_MAX] respectively.
REQ-021 If status[6] (X overflow) is set, commit SHALL leave Xpos unchanged; status[7] SHALL do the same for Ypos.
REQ-022 Commit SHALL load key_down with status[0], status[1], status[2].
REQ-023 Xpos, Ypos, key_down and oTrig SHALL update on the clock edge following the edge that samples the third rx_valid (1-cycle latency).
REQ-024 oTrig SHALL be high for exactly one cycle per commit, including commits where both axes are overflow-discarded.
REQ-025 A timeout counter SHALL reset on every accepted byte and count while in B1 or B2.
REQ-026 When the counter reaches TIMEOUT_CYC, the FSM SHALL return to B0 and drop the partial packet; outputs SHALL be unchanged.
REQ-027 rx_err in any state SHALL force B0 and drop the partial packet; rx_err SHALL win over a coincident rx_valid.
REQ-028 Back-to-back rx_valid on consecutive cycles SHALL be accepted without loss.

Reset
REQ-029 On rst: FSM=B0, Xpos=H_MAX/2+1 (320), Ypos=V_MAX/2+1 (240), key_down=0, oTrig=0, timeout counter=0, latched bytes=0.
REQ-030 rst asserted mid-packet SHALL discard the partial packet; the first byte after deassertion SHALL be treated as byte 0.

Structure
REQ-031 Shared package ps2_mouse_pkg SHALL hold the FSM state encoding, the status-bit index constants and the default H_MAX/V_MAX/TIMEOUT_CYC values.
REQ-032 One sub-module, ps2_axis_clamp (signed add, overflow hold, range clamp), SHALL be instantiated twice, once per axis.
REQ-033 Outputs SHALL be registered; no combinational path from rx_* to any output.

Verification
REQ-034 Test 1: after reset, send packet 0x09,0x0A,0x05 -> one oTrig; Xpos=330; Ypos=235; key_down=3'b001.
REQ-035 Test 2: from reset, send 0x18,0x00,0x00 (dx=-256), then repeat -> Xpos=64 after the first packet, 0 after the second; no wrap-around.
REQ-036 Test 3: send stray 0x05, then 0x08,0x01,0x01 -> first byte dropped; single oTrig; Xpos=321; Ypos=239.
REQ-037 Test 4: send 0x08,0x10, wait TIMEOUT_CYC+1 cycles, then 0x08,0x02,0x00 -> only the second packet commits; Xpos=322.
REQ-038 Test 5: send 0x48,0x7F,0x03 (X overflow) -> oTrig pulses; Xpos stays 320; Ypos=237.
REQ-039 Test 6: assert rx_err together with the byte-2 rx_valid, and separately assert rst after byte 1 -> no oTrig in either case; outputs hold, or return to reset values under rst.
